// File: rtl/matmul_dot_stream.sv
// matmul_dot_stream: two-stage streaming dot-product engine with ready/valid handshake
// and row-major row/col/last tagging. Define MATMUL_SIGNED_EN for two's complement elements.
module matmul_dot_stream #(
    parameter int N   = 3,
    parameter int W   = 8,
    parameter int DIM = 3,
    localparam int OUT_W = 2*W + $clog2(N),
    localparam int TW    = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0][W-1:0]   row1,
    input  logic [N-1:0][W-1:0]   col2,
    input  logic                  axiiv,
    output logic                  axiir,
    input  logic                  tag_clr,
    output logic [OUT_W-1:0]      axiod,
    output logic [TW-1:0]         axiod_row,
    output logic [TW-1:0]         axiod_col,
    output logic                  axiod_last,
    output logic                  axiov,
    input  logic                  axior
);

    localparam int PW = 2*W;
    localparam logic [TW-1:0] LAST = TW'(DIM - 1);

    logic                  en;
    logic                  accept;
    logic [N-1:0][PW-1:0]  prod_d;
    logic [N-1:0][PW-1:0]  prod_q;
    logic                  v1;
    logic [TW-1:0]         s1_row;
    logic [TW-1:0]         s1_col;
    logic [OUT_W-1:0]      sum;
    logic [TW-1:0]         cnt_row;
    logic [TW-1:0]         cnt_col;
    logic [TW-1:0]         base_row;
    logic [TW-1:0]         base_col;
    logic [TW-1:0]         nxt_row;
    logic [TW-1:0]         nxt_col;

    // A single enable stalls the whole pipe only when the output slot is occupied and blocked.
    assign en     = !axiov || axior;
    assign axiir  = en;
    assign accept = axiiv && en;

    always_comb begin
        prod_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef MATMUL_SIGNED_EN
            prod_d[i] = PW'($signed(row1[i])) * PW'($signed(col2[i]));
`else
            prod_d[i] = PW'(row1[i]) * PW'(col2[i]);
`endif
        end
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
`ifdef MATMUL_SIGNED_EN
            sum = sum + OUT_W'($signed(prod_q[i]));
`else
            sum = sum + OUT_W'(prod_q[i]);
`endif
        end
    end

    // tag_clr coinciding with a beat tags that beat (0,0) and counts on from there.
    always_comb begin
        base_row = tag_clr ? '0 : cnt_row;
        base_col = tag_clr ? '0 : cnt_col;
        nxt_row  = base_row;
        nxt_col  = base_col + TW'(1);
        if (base_col == LAST) begin
            nxt_col = '0;
            nxt_row = (base_row == LAST) ? '0 : base_row + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_row <= '0;
            cnt_col <= '0;
        end else if (accept) begin
            cnt_row <= nxt_row;
            cnt_col <= nxt_col;
        end else if (tag_clr) begin
            cnt_row <= '0;
            cnt_col <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1         <= 1'b0;
            prod_q     <= '0;
            s1_row     <= '0;
            s1_col     <= '0;
            axiov      <= 1'b0;
            axiod      <= '0;
            axiod_row  <= '0;
            axiod_col  <= '0;
            axiod_last <= 1'b0;
        end else if (en) begin
            v1         <= axiiv;
            prod_q     <= prod_d;
            s1_row     <= base_row;
            s1_col     <= base_col;
            axiov      <= v1;
            axiod      <= sum;
            axiod_row  <= s1_row;
            axiod_col  <= s1_col;
            axiod_last <= (s1_row == LAST) && (s1_col == LAST);
        end
    end

endmodule

// File: tb/tb_matmul_dot_stream.sv
// Directed self-checking bench for matmul_dot_stream (default N=3, W=8, DIM=3).
module tb_matmul_dot_stream;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int OUT_W = 18;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  c;
        logic        l;
    } res_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][W-1:0] row1;
    logic [N-1:0][W-1:0] col2;
    logic                axiiv;
    logic                axiir;
    logic                tag_clr;
    logic [OUT_W-1:0]    axiod;
    logic [1:0]          axiod_row;
    logic [1:0]          axiod_col;
    logic                axiod_last;
    logic                axiov;
    logic                axior;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t rx[$];
    res_t ex[$];

    matmul_dot_stream #(.N(N), .W(W), .DIM(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .row1       (row1),
        .col2       (col2),
        .axiiv      (axiiv),
        .axiir      (axiir),
        .tag_clr    (tag_clr),
        .axiod      (axiod),
        .axiod_row  (axiod_row),
        .axiod_col  (axiod_col),
        .axiod_last (axiod_last),
        .axiov      (axiov),
        .axior      (axior)
    );

    always #5 clk = ~clk;

    // Record every result that will be consumed at the following rising edge.
    always @(negedge clk) begin
        res_t t;
        if (rst && axiov && axior) begin
            t.d = 32'(axiod);
            t.r = axiod_row;
            t.c = axiod_col;
            t.l = axiod_last;
            rx.push_back(t);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic clr);
        int unsigned cyc;
        row1    = a;
        col2    = b;
        tag_clr = clr;
        axiiv   = 1'b1;
        cyc     = 0;
        forever begin
            @(negedge clk);
            if (axiir) begin
                step();
                break;
            end
            cyc++;
            if (cyc > 50) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tag_clr = 1'b0;
    endtask

    task automatic idle();
        axiiv   = 1'b0;
        tag_clr = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] d, input logic [1:0] r, input logic [1:0] c,
                              input logic l);
        res_t t;
        t.d = d;
        t.r = r;
        t.c = c;
        t.l = l;
        ex.push_back(t);
    endtask

    task automatic drain(input string tag);
        int unsigned cyc;
        cyc = 0;
        while (rx.size() < ex.size() && cyc < 40) begin
            step();
            cyc++;
        end
        check({tag, "_count"}, 32'(rx.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < rx.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), rx[i].d, ex[i].d);
            check($sformatf("%s_row%0d", tag, i), 32'(rx[i].r), 32'(ex[i].r));
            check($sformatf("%s_col%0d", tag, i), 32'(rx[i].c), 32'(ex[i].c));
            check($sformatf("%s_last%0d", tag, i), 32'(rx[i].l), 32'(ex[i].l));
        end
        rx.delete();
        ex.delete();
    endtask

    initial begin
        logic [31:0] signed_exp;

        rst     = 1'b0;
        row1    = '0;
        col2    = '0;
        axiiv   = 1'b0;
        tag_clr = 1'b0;
        axior   = 1'b1;
        repeat (3) step();

        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_axiod", 32'(axiod), 32'd0);
        check("rst_row", 32'(axiod_row), 32'd0);
        check("rst_col", 32'(axiod_col), 32'd0);
        check("rst_last", 32'(axiod_last), 32'd0);
        check("rst_axiir", 32'(axiir), 32'd1);
        rst = 1'b1;

        // Nine all-ones beats: every dot product is 3, tags sweep row-major.
        beat({3{8'd1}}, {3{8'd1}}, 1'b0);
        check("lat_first_edge", 32'(axiov), 32'd0);
        beat({3{8'd1}}, {3{8'd1}}, 1'b0);
        check("lat_second_edge", 32'(axiov), 32'd1);
        check("lat_data", 32'(axiod), 32'd3);
        for (int k = 2; k < 9; k++) beat({3{8'd1}}, {3{8'd1}}, 1'b0);
        idle();
        for (int k = 0; k < 9; k++) expect_res(32'd3, 2'(k / 3), 2'(k % 3), k == 8);
        drain("ones");
        step();
        check("ones_idle_axiov", 32'(axiov), 32'd0);

        // Single beat {3,2,1}.{3,2,1} = 14; tags wrapped back to (0,0).
        beat({8'd3, 8'd2, 8'd1}, {8'd3, 8'd2, 8'd1}, 1'b0);
        idle();
        check("single_edge1_axiov", 32'(axiov), 32'd0);
        step();
        check("single_axiov", 32'(axiov), 32'd1);
        check("single_data", 32'(axiod), 32'd14);
        check("single_row", 32'(axiod_row), 32'd0);
        check("single_col", 32'(axiod_col), 32'd0);
        step();
        check("single_after_axiov", 32'(axiov), 32'd0);
        rx.delete();

        // Largest unsigned operands: 3*255*255 = 195075 fits in 18 bits.
        beat({3{8'hFF}}, {3{8'hFF}}, 1'b0);
        idle();
        step();
        check("max_axiov", 32'(axiov), 32'd1);
        check("max_data", 32'(axiod), 32'h2FA03);
        check("max_col", 32'(axiod_col), 32'd1);
        step();
        rx.delete();

        // tag_clr on its own restarts the counters; then a stalled stream of six beats.
        tag_clr = 1'b1;
        step();
        tag_clr = 1'b0;
        for (int k = 1; k <= 3; k++) beat({3{8'(k)}}, {3{8'd1}}, 1'b0);
        axior = 1'b0;
        row1  = {3{8'd4}};
        col2  = {3{8'd1}};
        axiiv = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            check($sformatf("stall_axiir%0d", s), 32'(axiir), 32'd0);
            check($sformatf("stall_axiov%0d", s), 32'(axiov), 32'd1);
            check($sformatf("stall_data%0d", s), 32'(axiod), 32'd6);
            check($sformatf("stall_col%0d", s), 32'(axiod_col), 32'd1);
        end
        axior = 1'b1;
        for (int k = 4; k <= 6; k++) beat({3{8'(k)}}, {3{8'd1}}, 1'b0);
        idle();
        for (int k = 1; k <= 6; k++) expect_res(32'(3 * k), 2'((k - 1) / 3), 2'((k - 1) % 3), 1'b0);
        drain("stall");

        // Counters now at (2,0); tag_clr with beat 4 retags it (0,0).
        for (int k = 1; k <= 5; k++) beat({8'(k), 8'd0, 8'd0}, {3{8'd1}}, k == 4);
        idle();
        expect_res(32'd1, 2'd2, 2'd0, 1'b0);
        expect_res(32'd2, 2'd2, 2'd1, 1'b0);
        expect_res(32'd3, 2'd2, 2'd2, 1'b1);
        expect_res(32'd4, 2'd0, 2'd0, 1'b0);
        expect_res(32'd5, 2'd0, 2'd1, 1'b0);
        drain("clr");

        // Reset with two results in flight.
        beat({3{8'd7}}, {3{8'd1}}, 1'b0);
        beat({3{8'd8}}, {3{8'd1}}, 1'b0);
        idle();
        check("pre_rst_axiov", 32'(axiov), 32'd1);
        rst = 1'b0;
        #2;
        check("midrst_axiov", 32'(axiov), 32'd0);
        check("midrst_axiod", 32'(axiod), 32'd0);
        check("midrst_col", 32'(axiod_col), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("postrst_axiov", 32'(axiov), 32'd0);
        step();
        check("postrst_axiov2", 32'(axiov), 32'd0);
        rx.delete();
        beat({3{8'd2}}, {3{8'd1}}, 1'b0);
        idle();
        expect_res(32'd6, 2'd0, 2'd0, 1'b0);
        drain("postrst");

        // All-FF row times all-01 column: -3 when signed, 765 when unsigned.
`ifdef MATMUL_SIGNED_EN
        signed_exp = 32'h3FFFD;
`else
        signed_exp = 32'd765;
`endif
        beat({3{8'hFF}}, {3{8'h01}}, 1'b0);
        idle();
        expect_res(signed_exp, 2'd0, 2'd1, 1'b0);
        drain("sign");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
